// File: rtl/servo_slew.sv
// APB3 slew-rate limiter for two servo axes: applied pulse widths ramp toward
// software targets by STEP on every divided tick, with snap and settle reporting.
module servo_slew #(
  parameter logic [31:0] PW_MIN     = 32'd100000,
  parameter logic [31:0] PW_MAX     = 32'd200000,
  parameter logic [31:0] PW_RESET   = 32'd150000,
  parameter logic [31:0] STEP_RESET = 32'd1000,
  parameter logic [31:0] DIV_RESET  = 32'd99999
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] x_pw,
  output logic [31:0] y_pw,
  output logic        x_settled,
  output logic        y_settled,
  output logic        settle_irq
);

  localparam logic [12:0] A_X_TGT = 13'h100;
  localparam logic [12:0] A_X_CUR = 13'h104;
  localparam logic [12:0] A_Y_TGT = 13'h110;
  localparam logic [12:0] A_Y_CUR = 13'h114;
  localparam logic [12:0] A_STEP  = 13'h120;
  localparam logic [12:0] A_DIV   = 13'h124;
  localparam logic [12:0] A_CTRL  = 13'h128;

  logic [31:0] r_x_tgt, r_y_tgt, r_x_pw, r_y_pw, r_step, r_div, r_cnt;
  logic        r_en, r_x_set, r_y_set, r_irq;

  logic [12:0] w_addr;
  logic        w_wr, w_tick, w_snap, w_both_n, w_cnt_clr;
  logic [31:0] w_x_tgt_n, w_y_tgt_n, w_x_pw_n, w_y_pw_n;
  logic        w_unused_addr;

  function automatic logic [31:0] clamp(input logic [31:0] d);
    if (d < PW_MIN)      return PW_MIN;
    else if (d > PW_MAX) return PW_MAX;
    else                 return d;
  endfunction

  // The gap is compared against step before any add/subtract, so no wrap occurs.
  function automatic logic [31:0] ramp(input logic [31:0] pw, input logic [31:0] tgt,
                                       input logic [31:0] step);
    if (pw < tgt)      return ((tgt - pw) <= step) ? tgt : pw + step;
    else if (pw > tgt) return ((pw - tgt) <= step) ? tgt : pw - step;
    else               return pw;
  endfunction

  assign w_addr        = PADDR[12:0];
  assign w_unused_addr = ^PADDR[31:13];
  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_tick        = r_en & (r_cnt == r_div);
  assign w_snap        = w_wr & (w_addr == A_CTRL) & PWDATA[1];
  assign w_cnt_clr     = ~r_en
                       | (w_wr & (w_addr == A_DIV))
                       | (w_wr & (w_addr == A_CTRL) & PWDATA[0] & ~r_en)
                       | w_tick;

  // A target written in the same cycle as a tick only takes effect from the next tick.
  assign w_x_tgt_n = (w_wr && w_addr == A_X_TGT) ? clamp(PWDATA) : r_x_tgt;
  assign w_y_tgt_n = (w_wr && w_addr == A_Y_TGT) ? clamp(PWDATA) : r_y_tgt;
  assign w_x_pw_n  = w_snap ? r_x_tgt : (w_tick ? ramp(r_x_pw, r_x_tgt, r_step) : r_x_pw);
  assign w_y_pw_n  = w_snap ? r_y_tgt : (w_tick ? ramp(r_y_pw, r_y_tgt, r_step) : r_y_pw);
  assign w_both_n  = (w_x_pw_n == w_x_tgt_n) & (w_y_pw_n == w_y_tgt_n);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_x_tgt <= PW_RESET;
      r_y_tgt <= PW_RESET;
      r_x_pw  <= PW_RESET;
      r_y_pw  <= PW_RESET;
      r_step  <= STEP_RESET;
      r_div   <= DIV_RESET;
      r_en    <= 1'b0;
      r_cnt   <= 32'd0;
      r_x_set <= 1'b1;
      r_y_set <= 1'b1;
      r_irq   <= 1'b0;
    end else begin
      r_x_tgt <= w_x_tgt_n;
      r_y_tgt <= w_y_tgt_n;
      r_x_pw  <= w_x_pw_n;
      r_y_pw  <= w_y_pw_n;
      if (w_wr && w_addr == A_STEP) r_step <= PWDATA;
      if (w_wr && w_addr == A_DIV)  r_div  <= PWDATA;
      if (w_wr && w_addr == A_CTRL) r_en   <= PWDATA[0];
      r_cnt   <= w_cnt_clr ? 32'd0 : r_cnt + 32'd1;
      r_x_set <= (w_x_pw_n == w_x_tgt_n);
      r_y_set <= (w_y_pw_n == w_y_tgt_n);
      r_irq   <= w_both_n & ~(r_x_set & r_y_set);
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        A_X_TGT: PRDATA = r_x_tgt;
        A_X_CUR: PRDATA = r_x_pw;
        A_Y_TGT: PRDATA = r_y_tgt;
        A_Y_CUR: PRDATA = r_y_pw;
        A_STEP:  PRDATA = r_step;
        A_DIV:   PRDATA = r_div;
        A_CTRL:  PRDATA = {28'd0, r_y_set, r_x_set, 1'b0, r_en};
        default: PRDATA = 32'd0;
      endcase
    end
  end

  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign x_pw       = r_x_pw;
  assign y_pw       = r_y_pw;
  assign x_settled  = r_x_set;
  assign y_settled  = r_y_set;
  assign settle_irq = r_irq;

endmodule

// File: tb/tb_servo_slew.sv
// Bench for servo_slew: directed APB traffic, expected values queued at issue
// time and compared by a negedge monitor.
module tb_servo_slew;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
  logic [31:0] PRDATA, x_pw, y_pw;
  logic        PREADY, PSLVERR, x_settled, y_settled, settle_irq;

  servo_slew dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .x_pw(x_pw), .y_pw(y_pw), .x_settled(x_settled), .y_settled(y_settled),
    .settle_irq(settle_irq)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [31:0] exp_q[$];
  string       rd_nm_q[$];
  logic [66:0] out_q[$];
  string       out_nm_q[$];
  logic        probe_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          irq_cnt  = 0;

  // driver tasks: all entered at posedge + 1
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    rd_nm_q.push_back(nm);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic probe(input logic [31:0] x, input logic [31:0] y, input logic xs,
                       input logic ys, input logic irq, input string nm);
    out_q.push_back({x, y, xs, ys, irq});
    out_nm_q.push_back(nm);
    probe_en = 1'b1;
    @(posedge PCLK); #1 probe_en = 1'b0;
  endtask

  // monitor
  always @(negedge PCLK) begin
    if (settle_irq) irq_cnt++;
    if (PSEL && PENABLE && !PWRITE && PREADY) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_read: got %0d, no expected value queued", PRDATA);
      end else begin
        logic [31:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = rd_nm_q.pop_front();
        if (PRDATA !== e) begin
          n_errors++;
          $display("FAIL %s: PRDATA got %0d (0x%0h), expected %0d (0x%0h)", nm, PRDATA, PRDATA, e, e);
        end
      end
    end
    if (probe_en) begin
      logic [66:0] e, g;
      string nm;
      n_checks++;
      e  = out_q.pop_front();
      nm = out_nm_q.pop_front();
      g  = {x_pw, y_pw, x_settled, y_settled, settle_irq};
      if (g !== e) begin
        n_errors++;
        $display("FAIL %s: got x_pw=%0d y_pw=%0d xs=%0b ys=%0b irq=%0b, expected x_pw=%0d y_pw=%0d xs=%0b ys=%0b irq=%0b",
                 nm, g[66:35], g[34:3], g[2], g[1], g[0], e[66:35], e[34:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(posedge PCLK); #1;

    // reset state
    probe(150000, 150000, 1, 1, 0, "reset_outputs");
    apb_read(32'h104, 150000, "reset_x_current");
    apb_read(32'h114, 150000, "reset_y_current");
    apb_read(32'h128, 32'h0C, "reset_status");

    // DIV=0 ramp on X
    apb_write(32'h124, 0);
    apb_write(32'h120, 1000);
    apb_write(32'h128, 1);
    apb_write(32'h100, 155500);
    probe(150000, 150000, 0, 1, 0, "ramp_start");
    for (int k = 1; k <= 5; k++) probe(150000 + 1000 * k, 150000, 0, 1, 0, "ramp_step");
    probe(155500, 150000, 1, 1, 1, "ramp_final_irq");
    probe(155500, 150000, 1, 1, 0, "ramp_irq_one_cycle");

    // clamping
    apb_write(32'h100, 50000);
    apb_write(32'h110, 300000);
    apb_read(32'h100, 100000, "clamp_x_low");
    apb_read(32'h110, 200000, "clamp_y_high");
    repeat (120) @(posedge PCLK);
    #1;
    probe(100000, 200000, 1, 1, 0, "clamp_ramp_end");
    apb_read(32'h104, 100000, "clamp_x_current");
    apb_read(32'h114, 200000, "clamp_y_current");

    // DIV=9 paced ramp, then reset mid-ramp
    apb_write(32'h128, 0);
    apb_write(32'h120, 2500);
    apb_write(32'h124, 9);
    apb_write(32'h100, 140000);
    apb_write(32'h110, 160000);
    apb_write(32'h128, 1);
    for (int c = 0; c < 30; c++)
      probe(100000 + 2500 * (c / 10), 200000 - 2500 * (c / 10), 0, 0, 0, "div9_ramp");
    PRESET = 1'b1;
    probe(150000, 150000, 1, 1, 0, "reset_mid_ramp");
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(posedge PCLK); #1;
    apb_read(32'h128, 32'h0C, "reset_enable_cleared");
    apb_read(32'h120, 1000, "reset_step");
    apb_read(32'h124, 99999, "reset_div");
    apb_read(32'h100, 150000, "reset_x_target");

    // snap while disabled, then snap colliding with a tick
    apb_write(32'h100, 190000);
    probe(150000, 150000, 0, 1, 0, "pre_snap");
    apb_write(32'h128, 2);
    probe(190000, 150000, 1, 1, 1, "snap_x");
    probe(190000, 150000, 1, 1, 0, "snap_x_hold");
    apb_write(32'h124, 0);
    apb_write(32'h120, 1000);
    apb_write(32'h128, 1);
    apb_write(32'h110, 170000);
    apb_write(32'h128, 3);
    probe(190000, 170000, 1, 1, 1, "snap_over_tick");
    probe(190000, 170000, 1, 1, 0, "snap_over_tick_hold");

    // STEP=0 holds, unmapped accesses
    apb_write(32'h120, 0);
    apb_write(32'h100, 180000);
    for (int k = 0; k < 5; k++) probe(190000, 170000, 0, 1, 0, "step0_hold");
    apb_read(32'h128, 32'h09, "step0_status");
    apb_read(32'h104, 190000, "step0_x_current");
    apb_write(32'h12C, 32'hFFFF);
    apb_read(32'h120, 0, "unmapped_write_ignored");
    apb_read(32'h130, 0, "unmapped_read_130");
    apb_read(32'h108, 0, "unmapped_read_108");

    repeat (2) @(posedge PCLK);
    #1;
    n_checks++;
    if (irq_cnt != 4) begin
      n_errors++;
      $display("FAIL irq_count: got %0d pulses, expected 4", irq_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0 || out_q.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: got %0d/%0d left, expected 0/0", exp_q.size(), out_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
